// File: rtl/mod_seq_pkg.sv
// Shared types and constants for the modular sequential ALU.
// Holds the FSM state encoding, the op codes and the operand/modulus limits.
package mod_seq_pkg;

    localparam int OPW = 4;
    localparam logic [OPW-1:0] MOD_MIN = 4'd9;
    localparam logic [OPW-1:0] MOD_MAX = 4'd15;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        DBL  = 3'd2,
        MADD = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/mod_addsub.sv
// Combinational modular add/subtract: r = (a +/- b) mod m for a, b < m.
// Computed at 5 bits with one conditional correction by m.
module mod_addsub
    import mod_seq_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    input  logic           s,
    input  logic [OPW-1:0] m,
    output logic [OPW-1:0] r
);

    logic [OPW:0] sum;
    logic [OPW:0] fixed;

    always_comb begin
        sum   = '0;
        fixed = '0;
        if (s) begin
            sum = {1'b0, a} - {1'b0, b};
            // A borrow shows up in the top bit; adding m wraps it back into range.
            fixed = sum[OPW] ? (sum + {1'b0, m}) : sum;
        end else begin
            sum   = {1'b0, a} + {1'b0, b};
            fixed = (sum >= {1'b0, m}) ? (sum - {1'b0, m}) : sum;
        end
        r = fixed[OPW-1:0];
    end

endmodule

// File: rtl/mod_alu_seq.sv
// Sequential modular ALU: add/sub in one calc step, mul by MSB-first
// double-and-add over 4 fixed DBL/MADD pairs; valid/ready on both sides.
module mod_alu_seq
    import mod_seq_pkg::*;
#(
    parameter logic [3:0] M = 4'b1111
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     op,
    input  logic [OPW-1:0] x,
    input  logic [OPW-1:0] y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OPW-1:0] z,
    output logic           err
);

    generate
        if (M < MOD_MIN || M > MOD_MAX) begin : g_bad_modulus
            $error("mod_alu_seq: modulus M outside 9..15");
        end
    endgenerate

    state_t         state_reg, state_next;
    logic [1:0]     op_reg, op_next;
    logic [OPW-1:0] x_reg, x_next;
    logic [OPW-1:0] y_reg, y_next;
    logic [OPW-1:0] acc_reg, acc_next;
    logic [OPW-1:0] z_reg, z_next;
    logic           err_reg, err_next;
    logic [1:0]     bit_reg, bit_next;

    logic [OPW-1:0] as_a, as_b, as_r;
    logic           as_s;

    mod_addsub u_addsub (
        .a (as_a),
        .b (as_b),
        .s (as_s),
        .m (M),
        .r (as_r)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            op_reg    <= OP_ADD;
            x_reg     <= '0;
            y_reg     <= '0;
            acc_reg   <= '0;
            z_reg     <= '0;
            err_reg   <= 1'b0;
            bit_reg   <= 2'd3;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            acc_reg   <= acc_next;
            z_reg     <= z_next;
            err_reg   <= err_next;
            bit_reg   <= bit_next;
        end
    end

    // The single adder is steered by state: operands in CALC, acc+acc in DBL, acc+x in MADD.
    always_comb begin
        as_a = '0;
        as_b = '0;
        as_s = 1'b0;
        case (state_reg)
            CALC: begin
                as_a = x_reg;
                as_b = y_reg;
                as_s = (op_reg == OP_SUB);
            end
            DBL: begin
                as_a = acc_reg;
                as_b = acc_reg;
            end
            MADD: begin
                as_a = acc_reg;
                as_b = x_reg;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        acc_next   = acc_reg;
        z_next     = z_reg;
        err_next   = err_reg;
        bit_next   = bit_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    op_next  = op;
                    x_next   = x;
                    y_next   = y;
                    acc_next = '0;
                    bit_next = 2'd3;
                    if (op == OP_RSV || x >= M || y >= M) begin
                        err_next   = 1'b1;
                        z_next     = '0;
                        state_next = DONE;
                    end else begin
                        err_next   = 1'b0;
                        state_next = (op == OP_MUL) ? DBL : CALC;
                    end
                end
            end
            CALC: begin
                z_next     = as_r;
                state_next = DONE;
            end
            DBL: begin
                acc_next   = as_r;
                state_next = MADD;
            end
            MADD: begin
                if (y_reg[bit_reg]) begin
                    acc_next = as_r;
                end
                if (bit_reg == 2'd0) begin
                    z_next     = y_reg[0] ? as_r : acc_reg;
                    state_next = DONE;
                end else begin
                    bit_next   = bit_reg - 2'd1;
                    state_next = DBL;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign z         = z_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_mod_alu_seq.sv
// Bench for mod_alu_seq: two instances (M=9, M=15), directed vector table,
// stall and reset sequences, random traffic and an exhaustive legal sweep.
module tb_mod_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n_s     [2];
    logic       in_valid_s  [2];
    logic [1:0] op_s        [2];
    logic [3:0] x_s         [2];
    logic [3:0] y_s         [2];
    logic       out_ready_s [2];

    logic       in_ready0, out_valid0, err0;
    logic       in_ready1, out_valid1, err1;
    logic [3:0] z0, z1;

    int n_cmp = 0;
    int n_bad = 0;
    int hs_cnt [2];

    always #5 clk = ~clk;

    mod_alu_seq #(.M(4'd9)) dut9 (
        .clk(clk), .rst_n(rst_n_s[0]), .in_valid(in_valid_s[0]), .in_ready(in_ready0),
        .op(op_s[0]), .x(x_s[0]), .y(y_s[0]), .out_valid(out_valid0),
        .out_ready(out_ready_s[0]), .z(z0), .err(err0)
    );

    mod_alu_seq #(.M(4'd15)) dut15 (
        .clk(clk), .rst_n(rst_n_s[1]), .in_valid(in_valid_s[1]), .in_ready(in_ready1),
        .op(op_s[1]), .x(x_s[1]), .y(y_s[1]), .out_valid(out_valid1),
        .out_ready(out_ready_s[1]), .z(z1), .err(err1)
    );

    initial begin
        hs_cnt[0] = 0;
        hs_cnt[1] = 0;
    end

    always @(posedge clk) begin
        if (out_valid0 && out_ready_s[0]) hs_cnt[0] <= hs_cnt[0] + 1;
        if (out_valid1 && out_ready_s[1]) hs_cnt[1] <= hs_cnt[1] + 1;
    end

    function automatic int mod_of(input int k);
        return (k == 0) ? 9 : 15;
    endfunction
    function automatic logic get_ir(input int k);
        return (k == 0) ? in_ready0 : in_ready1;
    endfunction
    function automatic logic get_ov(input int k);
        return (k == 0) ? out_valid0 : out_valid1;
    endfunction
    function automatic logic get_err(input int k);
        return (k == 0) ? err0 : err1;
    endfunction
    function automatic logic [3:0] get_z(input int k);
        return (k == 0) ? z0 : z1;
    endfunction

    // Reference: plain modular arithmetic on integers.
    task automatic ref_model(input int m, input int o, input int a, input int b,
                             output int ez, output int eerr, output int elat);
        if (o == 3 || a >= m || b >= m) begin
            ez = 0; eerr = 1; elat = 1;
        end else begin
            eerr = 0;
            case (o)
                0:       begin ez = (a + b) % m;           elat = 2; end
                1:       begin ez = ((a - b) % m + m) % m; elat = 2; end
                default: begin ez = (a * b) % m;           elat = 9; end
            endcase
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One request with out_ready=1; junk is driven on the inputs while busy.
    task automatic txn(input int k, input int o, input int a, input int b,
                       output int zr, output int er, output int lat);
        @(negedge clk);
        if (!get_ir(k)) begin
            n_cmp++; n_bad++;
            $display("FAIL in_ready_before_req: got 0, expected 1");
        end
        in_valid_s[k]  = 1'b1;
        op_s[k]        = 2'(o);
        x_s[k]         = 4'(a);
        y_s[k]         = 4'(b);
        out_ready_s[k] = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        op_s[k] = 2'($urandom_range(3));
        x_s[k]  = 4'($urandom_range(15));
        y_s[k]  = 4'($urandom_range(15));
        @(negedge clk);
        while (!get_ov(k) && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        zr = int'(get_z(k));
        er = int'(get_err(k));
        in_valid_s[k] = 1'b0;
        @(posedge clk);
    endtask

    typedef struct {
        int k; int o; int a; int b; int ez; int eerr; int elat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int zr, er, lat, ez, eerr, elat, seen, hs0, zh;
        for (int k = 0; k < 2; k++) begin
            rst_n_s[k] = 1'b0; in_valid_s[k] = 1'b0; op_s[k] = 2'b00;
            x_s[k] = 4'd0; y_s[k] = 4'd0; out_ready_s[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_in_ready", int'(get_ir(k)), 1);
            check("reset_out_valid", int'(get_ov(k)), 0);
            check("reset_z_err", int'({get_err(k), get_z(k)}), 0);
        end
        rst_n_s[0] = 1'b1;
        rst_n_s[1] = 1'b1;

        // Directed vectors: {inst, op, x, y, z, err, latency}
        vecs[0] = '{1, 0, 9, 8, 2, 0, 2};
        vecs[1] = '{1, 1, 3, 7, 11, 0, 2};
        vecs[2] = '{1, 2, 7, 13, 1, 0, 9};
        vecs[3] = '{0, 2, 8, 8, 1, 0, 9};
        vecs[4] = '{0, 0, 15, 2, 0, 1, 1};
        vecs[5] = '{0, 2, 3, 15, 0, 1, 1};
        vecs[6] = '{0, 3, 1, 2, 0, 1, 1};
        vecs[7] = '{0, 1, 0, 8, 1, 0, 2};
        foreach (vecs[i]) begin
            txn(vecs[i].k, vecs[i].o, vecs[i].a, vecs[i].b, zr, er, lat);
            check("vec_z", zr, vecs[i].ez);
            check("vec_err", er, vecs[i].eerr);
            check("vec_latency", lat, vecs[i].elat);
            $display("vec %0d: M=%0d op=%0d x=%0d y=%0d -> z=%0d err=%0d lat=%0d",
                     i, mod_of(vecs[i].k), vecs[i].o, vecs[i].a, vecs[i].b, zr, er, lat);
        end

        // Output stall: result and flags must hold while out_ready is low.
        @(negedge clk);
        in_valid_s[1] = 1'b1; op_s[1] = 2'd2; x_s[1] = 4'd7; y_s[1] = 4'd13;
        out_ready_s[1] = 1'b0;
        @(posedge clk);
        #1 in_valid_s[1] = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid1 && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        check("stall_latency", lat, 9);
        zh = int'(z1);
        check("stall_z", zh, 1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_hold", int'({out_valid1, in_ready1, err1, z1}), int'({1'b1, 1'b0, 1'b0, 4'(zh)}));
        end
        out_ready_s[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("stall_release", int'({out_valid1, in_ready1}), 2'b01);
        $display("stall: mul 7*13 held 5 cycles, z=%0d", zh);

        // Reset on the 4th edge counting the acceptance edge as the first.
        @(negedge clk);
        in_valid_s[0] = 1'b1; op_s[0] = 2'd2; x_s[0] = 4'd5; y_s[0] = 4'd7;
        seen = 0;
        @(posedge clk);
        #1 in_valid_s[0] = 1'b0;
        @(posedge clk);
        @(negedge clk); if (out_valid0) seen = 1;
        @(posedge clk);
        @(negedge clk); if (out_valid0) seen = 1;
        rst_n_s[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_mid_in_ready", int'(in_ready0), 1);
        check("reset_mid_z_err", int'({err0, z0}), 0);
        rst_n_s[0] = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (out_valid0) seen = 1;
            @(negedge clk);
        end
        check("reset_no_out_valid", seen, 0);
        $display("reset: mul aborted on 4th edge, out_valid seen=%0d", seen);

        // Random traffic including illegal operands and the reserved op.
        for (int i = 0; i < 150; i++) begin
            int k, o, a, b;
            k = int'($urandom_range(1));
            o = int'($urandom_range(3));
            a = int'($urandom_range(15));
            b = int'($urandom_range(15));
            ref_model(mod_of(k), o, a, b, ez, eerr, elat);
            txn(k, o, a, b, zr, er, lat);
            check("rand_result", (er << 8) | (lat << 4) | zr, (eerr << 8) | (elat << 4) | ez);
            $display("rand %0d: M=%0d op=%0d x=%0d y=%0d -> z=%0d err=%0d lat=%0d", i, mod_of(k), o, a, b, zr, er, lat);
        end

        // Exhaustive legal sweep, one transaction per result.
        for (int k = 0; k < 2; k++) begin
            int m;
            m = mod_of(k);
            hs0 = hs_cnt[k];
            for (int o = 0; o < 3; o++)
                for (int a = 0; a < m; a++)
                    for (int b = 0; b < m; b++) begin
                        ref_model(m, o, a, b, ez, eerr, elat);
                        txn(k, o, a, b, zr, er, lat);
                        check("sweep_result", (er << 8) | (lat << 4) | zr, (eerr << 8) | (elat << 4) | ez);
                        $display("sweep: M=%0d op=%0d x=%0d y=%0d -> z=%0d err=%0d", m, o, a, b, zr, er);
                    end
            @(negedge clk);
            check("sweep_count", hs_cnt[k] - hs0, 3 * m * m);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mod_alu_seq.md
MOD_ALU_SEQ -- requirements
Module: mod_alu_seq

Interface
REQ-001 The block SHALL have parameter M, default 4'b1111: modulus, legal range 4'b1001..4'b1111; other values SHALL fail elaboration.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: request presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-006 The block SHALL have port op, input, 2 bits: 00 add, 01 sub, 10 mul, 11 reserved.
REQ-007 The block SHALL have ports x and y, input, 4 bits each: operands, unsigned.
REQ-008 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer takes result.
REQ-010 The block SHALL have port z, output, 4 bits: result, in range 0..M-1.
REQ-011 The block SHALL have port err, output, 1 bit: request rejected; qualified by out_valid.

Function
REQ-012 A request SHALL be accepted on an edge where in_valid=1 and in_ready=1; op, x and y SHALL be captured on that edge.
REQ-013 in_ready SHALL be 1 only in state IDLE.
REQ-014 The FSM SHALL have states IDLE, CALC, DBL, MADD and DONE.
REQ-015 On acceptance, the FSM SHALL go IDLE->CALC for add/sub and IDLE->DBL for mul; for op=11, or x>=M, or y>=M, it SHALL go IDLE->DONE with err=1 and z=0.
REQ-016 CALC SHALL register z=(x+y) mod M for add and z=(x-y) mod M (result+M if negative) for sub, then go to DONE.
REQ-017 Mul SHALL use MSB-first double-and-add over bits y[3]..y[0], with acc cleared on acceptance.
REQ-018 In DBL, acc SHALL become (acc+acc) mod M; in MADD, acc SHALL become (acc+x) mod M if the current y bit is 1, else acc unchanged.
REQ-019 Mul SHALL always run exactly 4 DBL/MADD pairs (fixed latency); after the 4th MADD, z=acc and the FSM SHALL go to DONE.
REQ-020 Latency from the acceptance edge to the first cycle with out_valid=1 SHALL be 2 edges for add/sub, 9 edges for mul, and 1 edge for an error.
REQ-021 out_valid SHALL be 1 only in DONE; z and err SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 An edge in DONE with out_ready=1 SHALL go to IDLE and deassert out_valid; the next acceptance is possible one edge later (no back-to-back overlap).
REQ-023 in_valid, op, x and y SHALL be ignored outside IDLE.
REQ-024 All modular add/sub SHALL be computed at 5 bits, with a single conditional correction by M.

Reset
REQ-025 An edge with rst_n=0 SHALL force state IDLE, acc=0, z=0, err=0 and out_valid=0, with in_ready=1 from the following cycle.
REQ-026 Reset mid-operation (any state) SHALL abort the operation; no out_valid SHALL be produced for the aborted request.

Structure
REQ-027 Package mod_seq_pkg SHALL hold: the state enum, the op codes (OP_ADD, OP_SUB, OP_MUL, OP_RSV), operand width 4, and modulus bounds 9/15.
REQ-028 One combinational sub-module, mod_addsub (a, b, s, m -> r), SHALL be instantiated once and shared by CALC, DBL and MADD.

Verification
REQ-029 With M=15, add x=9, y=8 -> z=2, err=0, out_valid 2 edges after acceptance.
REQ-030 With M=15, sub x=3, y=7 -> z=11; mul x=7, y=13 -> z=1, out_valid 9 edges after acceptance.
REQ-031 With M=9, mul x=8, y=8 -> z=1; x=15 with any op -> err=1, z=0, 1-edge latency; op=11 -> err=1.
REQ-032 Mul accepted, then out_ready held 0 for 5 cycles -> out_valid, z and err held and in_ready=0 throughout; release -> IDLE on the next edge.
REQ-033 rst_n=0 on the 4th edge after a mul acceptance -> out_valid never asserted and in_ready=1 the cycle after reset.
REQ-034 Exhaustive sweep for M=9 and M=15, all ops and all legal x,y -> every z matches the reference model; total count = 3*M*M.
